multi_config_shift_reg: RTL and testbench



---
 rtl/multi_config_pkg.sv | 16 +
 rtl/multi_config_sr_stage.sv | 43 ++++
 rtl/multi_config_shift_reg.sv | 102 ++++++++++
 tb/tb_multi_config_shift_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_config_pkg.sv
// Shared definitions for the multi-configuration shift register:
// the operation-select encoding and a small decode helper.
package multi_config_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHL  = 2'b01,
        SHR  = 2'b10,
        LOAD = 2'b11
    } mode_t;

    function automatic logic is_shift(input mode_t m);
        return (m == SHL) || (m == SHR);
    endfunction

endpackage

// File: rtl/multi_config_sr_stage.sv
// One WIDTH-bit register stage selecting between hold, left-neighbour,
// right-neighbour and parallel data each clock.
module multi_config_sr_stage
    import multi_config_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] shl_in,
    input  logic [WIDTH-1:0] shr_in,
    input  logic [WIDTH-1:0] load_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] next_q;

    // An unknown or unlisted mode falls back to holding the stored word.
    always_comb begin
        next_q = q;
        case (mode)
            SHL:     next_q = shl_in;
            SHR:     next_q = shr_in;
            LOAD:    next_q = load_in;
            default: next_q = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/multi_config_shift_reg.sv
// Word-wide shift register with left/right shift, optional rotation,
// parallel load and a saturating count of valid stages.
module multi_config_shift_reg
    import multi_config_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter int               ROTATE  = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  mode_t                      mode,
    input  logic [WIDTH-1:0]           ser_in,
    input  logic [DEPTH*WIDTH-1:0]     par_in,
    output logic [WIDTH-1:0]           ser_out,
    output logic [DEPTH*WIDTH-1:0]     par_out,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
    output logic                       full
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] shl_head;
    logic [WIDTH-1:0] shr_tail;

    // With rotation the word falling off one end re-enters at the other.
    assign shl_head = (ROTATE != 0) ? stage_q[DEPTH-1] : ser_in;
    assign shr_tail = (ROTATE != 0) ? stage_q[0]       : ser_in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] shl_src;
        logic [WIDTH-1:0] shr_src;

        if (i == 0) begin : g_first
            assign shl_src = shl_head;
        end else begin : g_mid_l
            assign shl_src = stage_q[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign shr_src = shr_tail;
        end else begin : g_mid_r
            assign shr_src = stage_q[i+1];
        end

        multi_config_sr_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .en      (en),
            .mode    (mode),
            .shl_in  (shl_src),
            .shr_in  (shr_src),
            .load_in (par_in[i*WIDTH +: WIDTH]),
            .q       (stage_q[i])
        );

        assign par_out[i*WIDTH +: WIDTH] = stage_q[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_out  <= RST_VAL;
            fill_cnt <= '0;
        end else if (clr) begin
            ser_out  <= RST_VAL;
            fill_cnt <= '0;
        end else if (en) begin
            case (mode)
                SHL: ser_out <= stage_q[DEPTH-1];
                SHR: ser_out <= stage_q[0];
                default: ser_out <= ser_out;
            endcase
            // Rotation never introduces new data, so only plain shifts count.
            if (mode == LOAD) begin
                fill_cnt <= CNT_MAX;
            end else if (is_shift(mode) && (ROTATE == 0) && (fill_cnt != CNT_MAX)) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
        end
    end

    assign full = (fill_cnt == CNT_MAX);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && en && !clr) begin
            assert (!$isunknown(mode))
                else $error("mode is unknown while enabled");
        end
    end
`endif

endmodule

// File: tb/tb_multi_config_shift_reg.sv
// Bench for multi_config_shift_reg: hand vectors on 4-deep instances plus a
// random run over depths 2, 4 and 64 checked against queue models.
module tb_multi_config_shift_reg;
    import multi_config_pkg::*;

    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         clr;
    mode_t        mode;
    logic [7:0]   ser_in;
    logic [511:0] par_in;

    logic [31:0]  par_a, par_b;
    logic [15:0]  par_c;
    logic [511:0] par_d;
    logic [7:0]   ser_a, ser_b, ser_c, ser_d;
    logic [2:0]   cnt_a, cnt_b;
    logic [1:0]   cnt_c;
    logic [6:0]   cnt_d;
    logic         full_a, full_b, full_c, full_d;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multi_config_shift_reg #(.WIDTH(8), .DEPTH(4), .ROTATE(0), .RST_VAL(RV)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .ser_in(ser_in),
        .par_in(par_in[31:0]), .ser_out(ser_a), .par_out(par_a), .fill_cnt(cnt_a), .full(full_a));
    multi_config_shift_reg #(.WIDTH(8), .DEPTH(4), .ROTATE(1), .RST_VAL(RV)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .ser_in(ser_in),
        .par_in(par_in[31:0]), .ser_out(ser_b), .par_out(par_b), .fill_cnt(cnt_b), .full(full_b));
    multi_config_shift_reg #(.WIDTH(8), .DEPTH(2), .ROTATE(0), .RST_VAL(RV)) dut_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .ser_in(ser_in),
        .par_in(par_in[15:0]), .ser_out(ser_c), .par_out(par_c), .fill_cnt(cnt_c), .full(full_c));
    multi_config_shift_reg #(.WIDTH(8), .DEPTH(64), .ROTATE(0), .RST_VAL(RV)) dut_d (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .ser_in(ser_in),
        .par_in(par_in), .ser_out(ser_d), .par_out(par_d), .fill_cnt(cnt_d), .full(full_d));

    typedef struct {
        logic        en;
        logic        clr;
        mode_t       mode;
        logic [7:0]  ser;
        logic [31:0] par;
        logic [31:0] exp_par;
        logic [7:0]  exp_ser;
        int          exp_cnt;
        logic        exp_full;
    } vec_t;

    vec_t vecs[$];

    // Reference models: element 0 of each queue is stage 0.
    logic [7:0] mq [4][$];
    logic [7:0] mser [4];
    int         mcnt [4];
    int         mdepth [4] = '{4, 4, 2, 64};
    bit         mrot [4]   = '{1'b0, 1'b1, 1'b0, 1'b0};

    task automatic add_vec(input logic e, input logic c, input mode_t m, input logic [7:0] s,
                           input logic [31:0] p, input logic [31:0] ep, input logic [7:0] es,
                           input int ec, input logic ef);
        vec_t v;
        v.en = e; v.clr = c; v.mode = m; v.ser = s; v.par = p;
        v.exp_par = ep; v.exp_ser = es; v.exp_cnt = ec; v.exp_full = ef;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic e, input logic c, input mode_t m,
                                  input logic [7:0] s, input logic [511:0] p);
        en = e; clr = c; mode = m; ser_in = s; par_in = p;
    endtask

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [31:0] ep, input logic [7:0] es,
                           input int ec, input logic ef);
        check_output({tag, " par_out"},  512'(par_a),  512'(ep));
        check_output({tag, " ser_out"},  512'(ser_a),  512'(es));
        check_output({tag, " fill_cnt"}, 512'(cnt_a),  512'(ec));
        check_output({tag, " full"},     512'(full_a), 512'(ef));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            for (int i = 0; i < mdepth[k]; i++) mq[k].push_back(RV);
            mser[k] = RV;
            mcnt[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] w;
        int d;
        d = mdepth[k];
        if (clr) begin
            for (int i = 0; i < d; i++) mq[k][i] = RV;
            mser[k] = RV;
            mcnt[k] = 0;
        end else if (en) begin
            case (mode)
                SHL: begin
                    w = mq[k].pop_back();
                    mq[k].push_front(mrot[k] ? w : ser_in);
                    mser[k] = w;
                    if (!mrot[k] && mcnt[k] < d) mcnt[k]++;
                end
                SHR: begin
                    w = mq[k].pop_front();
                    mq[k].push_back(mrot[k] ? w : ser_in);
                    mser[k] = w;
                    if (!mrot[k] && mcnt[k] < d) mcnt[k]++;
                end
                LOAD: begin
                    for (int i = 0; i < d; i++) mq[k][i] = par_in[i*8 +: 8];
                    mcnt[k] = d;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_unit(input int k);
        logic [511:0] exp_p, act_p, act_s, act_c, act_f;
        exp_p = '0;
        for (int i = 0; i < mdepth[k]; i++) exp_p[i*8 +: 8] = mq[k][i];
        case (k)
            0: begin act_p = 512'(par_a); act_s = 512'(ser_a); act_c = 512'(cnt_a); act_f = 512'(full_a); end
            1: begin act_p = 512'(par_b); act_s = 512'(ser_b); act_c = 512'(cnt_b); act_f = 512'(full_b); end
            2: begin act_p = 512'(par_c); act_s = 512'(ser_c); act_c = 512'(cnt_c); act_f = 512'(full_c); end
            default: begin act_p = par_d; act_s = 512'(ser_d); act_c = 512'(cnt_d); act_f = 512'(full_d); end
        endcase
        check_output($sformatf("rand u%0d par_out", k),  act_p, exp_p);
        check_output($sformatf("rand u%0d ser_out", k),  act_s, 512'(mser[k]));
        check_output($sformatf("rand u%0d fill_cnt", k), act_c, 512'(mcnt[k]));
        check_output($sformatf("rand u%0d full", k),     act_f, 512'(mcnt[k] == mdepth[k]));
    endtask

    initial begin
        logic [511:0] rp;

        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, HOLD, 8'h00, '0);
        repeat (2) step_cycle();
        check_a("reset", 32'hA5A5A5A5, RV, 0, 1'b0);
        rst = 1'b1;

        // Fill, saturate, hold while disabled, clear beating load, then mixed ops.
        add_vec(1, 0, SHL,  8'h11, 32'h0,        32'hA5A5A511, 8'hA5, 1, 0);
        add_vec(1, 0, SHL,  8'h22, 32'h0,        32'hA5A51122, 8'hA5, 2, 0);
        add_vec(1, 0, SHL,  8'h33, 32'h0,        32'hA5112233, 8'hA5, 3, 0);
        add_vec(1, 0, SHL,  8'h44, 32'h0,        32'h11223344, 8'hA5, 4, 1);
        add_vec(1, 0, SHL,  8'h55, 32'h0,        32'h22334455, 8'h11, 4, 1);
        add_vec(0, 0, SHL,  8'h66, 32'h0,        32'h22334455, 8'h11, 4, 1);
        add_vec(0, 0, SHL,  8'h67, 32'h0,        32'h22334455, 8'h11, 4, 1);
        add_vec(0, 0, SHL,  8'h68, 32'h0,        32'h22334455, 8'h11, 4, 1);
        add_vec(1, 1, LOAD, 8'h00, 32'h12345678, 32'hA5A5A5A5, 8'hA5, 0, 0);
        add_vec(1, 0, SHR,  8'h77, 32'h0,        32'h77A5A5A5, 8'hA5, 1, 0);
        add_vec(1, 0, LOAD, 8'h00, 32'hDEADBEEF, 32'hDEADBEEF, 8'hA5, 4, 1);
        add_vec(1, 0, SHR,  8'h01, 32'h0,        32'h01DEADBE, 8'hEF, 4, 1);
        add_vec(1, 0, HOLD, 8'h09, 32'h0,        32'h01DEADBE, 8'hEF, 4, 1);
        add_vec(1, 0, SHL,  8'h02, 32'h0,        32'hDEADBE02, 8'h01, 4, 1);

        for (int n = 0; n < vecs.size(); n++) begin
            apply_stimulus(vecs[n].en, vecs[n].clr, vecs[n].mode, vecs[n].ser, 512'(vecs[n].par));
            step_cycle();
            check_a($sformatf("vec%0d", n), vecs[n].exp_par, vecs[n].exp_ser,
                    vecs[n].exp_cnt, vecs[n].exp_full);
        end

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #3;
        rst = 1'b0;
        #1;
        check_a("async_rst", 32'hA5A5A5A5, RV, 0, 1'b0);
        apply_stimulus(1'b0, 1'b0, HOLD, 8'h00, '0);
        @(negedge clk) rst = 1'b1;
        step_cycle();

        // Rotating instance: shifts keep the count, load then two right rotations.
        apply_stimulus(1'b1, 1'b0, SHL, 8'h3C, '0);
        step_cycle();
        check_output("rot shl fill_cnt", 512'(cnt_b), 512'(0));
        check_output("rot shl par_out",  512'(par_b), 512'(32'hA5A5A5A5));
        apply_stimulus(1'b1, 1'b0, LOAD, 8'h00, 512'(32'h04030201));
        step_cycle();
        apply_stimulus(1'b1, 1'b0, SHR, 8'hFF, '0);
        step_cycle();
        check_output("rot shr1 ser_out", 512'(ser_b), 512'(8'h01));
        step_cycle();
        check_output("rot shr2 par_out",  512'(par_b),  512'(32'h02010403));
        check_output("rot shr2 ser_out",  512'(ser_b),  512'(8'h02));
        check_output("rot shr2 fill_cnt", 512'(cnt_b),  512'(4));
        check_output("rot shr2 full",     512'(full_b), 512'(1));

        // Reset landing just after a load edge discards the loaded data.
        apply_stimulus(1'b1, 1'b0, LOAD, 8'h00, 512'(32'h12345678));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_a("rst_after_load", 32'hA5A5A5A5, RV, 0, 1'b0);
        apply_stimulus(1'b1, 1'b0, SHL, 8'h99, '0);
        @(negedge clk) rst = 1'b1;
        step_cycle();
        check_a("first_shl", 32'hA5A5A599, RV, 1, 1'b0);

        // Random run shared by every instance.
        rst = 1'b0;
        model_reset();
        apply_stimulus(1'b0, 1'b0, HOLD, 8'h00, '0);
        #2;
        rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            for (int w = 0; w < 16; w++) rp[w*32 +: 32] = $urandom;
            apply_stimulus($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                           mode_t'($urandom_range(0, 3)), 8'($urandom), rp);
            for (int k = 0; k < 4; k++) model_step(k);
            step_cycle();
            for (int k = 0; k < 4; k++) check_unit(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
